// File: rtl/pipe_stream_checker.sv
// Receive-side sink for the two-lane global-stall pipeline: checks each lane
// against an arithmetic sequence, counts beats and drives LFSR backpressure.
module pipe_stream_checker #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] SEED_1    = 32'd0,
  parameter logic [31:0] SEED_2    = 32'd0,
  parameter logic [31:0] STEP      = 32'd1,
  parameter logic [15:0] NUM_BEATS = 16'd1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              in_valid_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic              in_valid_2,
  input  logic              stall_en,
  output logic              stall,
  output logic [15:0]       beats_1,
  output logic [15:0]       beats_2,
  output logic              err,
  output logic [1:0]        err_lane,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_actual,
  output logic              done
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
  logic [15:0]       beats1_q, beats1_d, beats2_q, beats2_d;
  logic              err_q, err_d;
  logic [1:0]        errLane_q, errLane_d;
  logic [DATA_W-1:0] errExp_q, errExp_d, errAct_q, errAct_d;
  logic              acc1, acc2, mis1, mis2;

  always_comb begin
    // Acceptance uses the registered stall the pipeline is also seeing this cycle.
    acc1 = in_valid_1 & ~stall_q & (state_q == RUN) & (beats1_q < NUM_BEATS);
    acc2 = in_valid_2 & ~stall_q & (state_q == RUN) & (beats2_q < NUM_BEATS);
    mis1 = acc1 & (in_data_1 != exp1_q);
    mis2 = acc2 & (in_data_2 != exp2_q);

    exp1_d   = exp1_q;
    exp2_d   = exp2_q;
    beats1_d = beats1_q;
    beats2_d = beats2_q;
    if (acc1) begin
      exp1_d   = exp1_q + DATA_W'(STEP);
      beats1_d = beats1_q + 16'd1;
    end
    if (acc2) begin
      exp2_d   = exp2_q + DATA_W'(STEP);
      beats2_d = beats2_q + 16'd1;
    end

    // Only the first mismatch is captured; lane 1 wins the data pair on a tie.
    err_d     = err_q;
    errLane_d = errLane_q;
    errExp_d  = errExp_q;
    errAct_d  = errAct_q;
    if (~err_q & (mis1 | mis2)) begin
      err_d     = 1'b1;
      errLane_d = {mis2, mis1};
      errExp_d  = mis1 ? exp1_q : exp2_q;
      errAct_d  = mis1 ? in_data_1 : in_data_2;
    end

    state_d = state_q;
    if ((state_q == RUN) && (beats1_d == NUM_BEATS) && (beats2_d == NUM_BEATS)) begin
      state_d = DONE;
    end

    stall_d = (state_q == DONE) ? 1'b1 : (stall_en & (lfsr_q[1:0] == 2'b00));
    lfsr_d  = stall_en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                       : lfsr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      lfsr_q    <= LFSR_SEED;
      stall_q   <= 1'b0;
      exp1_q    <= DATA_W'(SEED_1);
      exp2_q    <= DATA_W'(SEED_2);
      beats1_q  <= 16'd0;
      beats2_q  <= 16'd0;
      err_q     <= 1'b0;
      errLane_q <= 2'b00;
      errExp_q  <= '0;
      errAct_q  <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      stall_q   <= stall_d;
      exp1_q    <= exp1_d;
      exp2_q    <= exp2_d;
      beats1_q  <= beats1_d;
      beats2_q  <= beats2_d;
      err_q     <= err_d;
      errLane_q <= errLane_d;
      errExp_q  <= errExp_d;
      errAct_q  <= errAct_d;
    end
  end

  assign stall        = stall_q;
  assign beats_1      = beats1_q;
  assign beats_2      = beats2_q;
  assign err          = err_q;
  assign err_lane     = errLane_q;
  assign err_expected = errExp_q;
  assign err_actual   = errAct_q;
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_pipe_stream_checker.sv
// Bench for pipe_stream_checker: a table-driven instance (8 beats, wrapping seed)
// and a scoreboard-checked instance (64 beats, LFSR backpressure, error capture).
module tb_pipe_stream_checker;

  localparam int          DW = 32;
  localparam logic [15:0] NA = 16'd64;
  localparam logic [15:0] NB = 16'd8;

  logic          clk = 1'b0;
  logic          resetA, resetB;
  logic [DW-1:0] inData1, inData2;
  logic          inValid1, inValid2, stallEn;

  logic          aStall, aErr, aDone, bStall, bErr, bDone;
  logic [15:0]   aBeats1, aBeats2, bBeats1, bBeats2;
  logic [1:0]    aErrLane, bErrLane;
  logic [DW-1:0] aErrExp, aErrAct, bErrExp, bErrAct;

  typedef struct {
    logic        stall;
    logic [15:0] b1;
    logic [15:0] b2;
    logic        err;
    logic [1:0]  lane;
    logic [31:0] ex;
    logic [31:0] ac;
    logic        done;
  } outRec_t;

  typedef struct {
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
    outRec_t     exp;
  } vec_t;

  outRec_t expQ[$];
  vec_t    vecs[12];
  int      errors = 0;
  int      checks = 0;

  // Reference model state for instance A
  logic        mStall, mErr, mDone;
  logic [15:0] mLfsr, mB1, mB2;
  logic [31:0] mExp1, mExp2, mEx, mAc;
  logic [1:0]  mLane;
  int          c1Beat, c2Beat;
  logic [31:0] c1Val, c2Val;

  pipe_stream_checker #(
    .DATA_W(DW), .SEED_1(32'd0), .SEED_2(32'd0), .STEP(32'd1),
    .NUM_BEATS(NA), .LFSR_SEED(16'hACE1)
  ) dutA (
    .clk(clk), .reset(resetA),
    .in_data_1(inData1), .in_valid_1(inValid1),
    .in_data_2(inData2), .in_valid_2(inValid2),
    .stall_en(stallEn), .stall(aStall),
    .beats_1(aBeats1), .beats_2(aBeats2),
    .err(aErr), .err_lane(aErrLane),
    .err_expected(aErrExp), .err_actual(aErrAct), .done(aDone)
  );

  pipe_stream_checker #(
    .DATA_W(DW), .SEED_1(32'hFFFF_FFFE), .SEED_2(32'd0), .STEP(32'd1),
    .NUM_BEATS(NB), .LFSR_SEED(16'hACE1)
  ) dutB (
    .clk(clk), .reset(resetB),
    .in_data_1(inData1), .in_valid_1(inValid1),
    .in_data_2(inData2), .in_valid_2(inValid2),
    .stall_en(stallEn), .stall(bStall),
    .beats_1(bBeats1), .beats_2(bBeats2),
    .err(bErr), .err_lane(bErrLane),
    .err_expected(bErrExp), .err_actual(bErrAct), .done(bDone)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Pops the next expected record and compares it with one instance's outputs.
  task automatic checkOutput(input bit useB);
    outRec_t r;
    if (expQ.size() == 0) begin
      checkField("queueEmpty", 32'd1, 32'd0);
      return;
    end
    r = expQ.pop_front();
    if (useB) begin
      checkField("bStall", 32'(bStall), 32'(r.stall));
      checkField("bBeats1", 32'(bBeats1), 32'(r.b1));
      checkField("bBeats2", 32'(bBeats2), 32'(r.b2));
      checkField("bErr", 32'(bErr), 32'(r.err));
      checkField("bDone", 32'(bDone), 32'(r.done));
    end else begin
      checkField("aStall", 32'(aStall), 32'(r.stall));
      checkField("aBeats1", 32'(aBeats1), 32'(r.b1));
      checkField("aBeats2", 32'(aBeats2), 32'(r.b2));
      checkField("aErr", 32'(aErr), 32'(r.err));
      checkField("aErrLane", 32'(aErrLane), 32'(r.lane));
      checkField("aErrExp", aErrExp, r.ex);
      checkField("aErrAct", aErrAct, r.ac);
      checkField("aDone", 32'(aDone), 32'(r.done));
    end
  endtask

  // Advances the reference model by one clock using the inputs currently driven.
  task automatic modelStep(input bit rst, input bit en);
    bit      acc1, acc2, mis1, mis2, nextStall;
    outRec_t r;
    if (rst) begin
      mStall = 1'b0; mErr = 1'b0; mDone = 1'b0; mLfsr = 16'hACE1;
      mB1 = 16'd0; mB2 = 16'd0; mExp1 = 32'd0; mExp2 = 32'd0;
      mEx = 32'd0; mAc = 32'd0; mLane = 2'b00;
    end else begin
      acc1 = inValid1 && !mStall && !mDone && (mB1 < NA);
      acc2 = inValid2 && !mStall && !mDone && (mB2 < NA);
      mis1 = acc1 && (inData1 !== mExp1);
      mis2 = acc2 && (inData2 !== mExp2);
      nextStall = mDone ? 1'b1 : (en && (mLfsr[1:0] == 2'b00));
      if (!mErr && (mis1 || mis2)) begin
        mErr  = 1'b1;
        mLane = {mis2, mis1};
        mEx   = mis1 ? mExp1 : mExp2;
        mAc   = mis1 ? inData1 : inData2;
      end
      if (acc1) begin mExp1 = mExp1 + 32'd1; mB1 = mB1 + 16'd1; end
      if (acc2) begin mExp2 = mExp2 + 32'd1; mB2 = mB2 + 16'd1; end
      if (en) mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
      mStall = nextStall;
      if (mB1 == NA && mB2 == NA) mDone = 1'b1;
    end
    r.stall = mStall; r.b1 = mB1; r.b2 = mB2; r.err = mErr;
    r.lane = mLane; r.ex = mEx; r.ac = mAc; r.done = mDone;
    expQ.push_back(r);
  endtask

  // One cycle on instance A: both lanes present their next beat, optionally corrupted.
  task automatic applyStimulus(input bit rst, input bit en);
    resetA   = rst;
    stallEn  = en;
    inValid1 = 1'b1;
    inValid2 = 1'b1;
    inData1  = (int'(mB1) == c1Beat) ? c1Val : 32'(mB1);
    inData2  = (int'(mB2) == c2Beat) ? c2Val : 32'(mB2);
    modelStep(rst, en);
    @(posedge clk);
    #1;
    checkOutput(1'b0);
  endtask

  task automatic runUntilDone(input int budget, input bit en);
    int n = 0;
    while (aDone !== 1'b1 && n < budget) begin
      applyStimulus(1'b0, en);
      n++;
    end
    checkField("doneWithinBudget", 32'(aDone), 32'd1);
  endtask

  task automatic checkResetA();
    checkField("rstStall", 32'(aStall), 32'd0);
    checkField("rstBeats1", 32'(aBeats1), 32'd0);
    checkField("rstBeats2", 32'(aBeats2), 32'd0);
    checkField("rstErr", 32'(aErr), 32'd0);
    checkField("rstErrLane", 32'(aErrLane), 32'd0);
    checkField("rstErrExp", aErrExp, 32'd0);
    checkField("rstErrAct", aErrAct, 32'd0);
    checkField("rstDone", 32'(aDone), 32'd0);
  endtask

  initial begin
    c1Beat = -1; c2Beat = -1; c1Val = 32'd0; c2Val = 32'd0;
    resetA = 1'b1; resetB = 1'b1; stallEn = 1'b0;
    inValid1 = 1'b0; inValid2 = 1'b0; inData1 = '0; inData2 = '0;
    modelStep(1'b1, 1'b0);
    void'(expQ.pop_front());

    // Table for instance B: 8 clean beats with lane-1 wrap, then lane-1-only extras.
    for (int i = 0; i < 12; i++) begin
      vecs[i].v1 = 1'b1;
      vecs[i].d1 = (i < 8) ? (32'hFFFF_FFFE + 32'(i)) : (32'hDEAD_0000 + 32'(i));
      vecs[i].v2 = (i < 8);
      vecs[i].d2 = 32'(i);
      vecs[i].exp.stall = (i >= 8);
      vecs[i].exp.b1    = (i < 8) ? 16'(i + 1) : NB;
      vecs[i].exp.b2    = (i < 8) ? 16'(i + 1) : NB;
      vecs[i].exp.err   = 1'b0;
      vecs[i].exp.lane  = 2'b00;
      vecs[i].exp.ex    = 32'd0;
      vecs[i].exp.ac    = 32'd0;
      vecs[i].exp.done  = (i >= 7);
    end

    repeat (2) @(posedge clk);
    #1;
    resetB = 1'b0;
    checkField("bRstBeats1", 32'(bBeats1), 32'd0);
    checkField("bRstStall", 32'(bStall), 32'd0);
    checkField("bRstDone", 32'(bDone), 32'd0);
    for (int i = 0; i < 12; i++) begin
      inValid1 = vecs[i].v1; inData1 = vecs[i].d1;
      inValid2 = vecs[i].v2; inData2 = vecs[i].d2;
      expQ.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      checkOutput(1'b1);
    end
    resetB = 1'b1;

    // Backpressure run on instance A with the LFSR enabled.
    applyStimulus(1'b1, 1'b0);
    checkResetA();
    runUntilDone(400, 1'b1);
    checkField("bpErr", 32'(aErr), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkField("bpStallAfterDone", 32'(aStall), 32'd1);

    // Lane 2 corrupted at beat 5, then a second mismatch on lane 1 at beat 10.
    c2Beat = 5; c2Val = 32'd99; c1Beat = 10; c1Val = 32'd1234;
    applyStimulus(1'b1, 1'b0);
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkField("l2ErrLane", 32'(aErrLane), 32'd2);
    checkField("l2ErrExp", aErrExp, 32'd5);
    checkField("l2ErrAct", aErrAct, 32'd99);
    checkField("l2Beats1", 32'(aBeats1), 32'd15);

    // Both lanes corrupted in the same cycle at beat 3.
    c1Beat = 3; c1Val = 32'd7; c2Beat = 3; c2Val = 32'd9;
    applyStimulus(1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkField("bothErrLane", 32'(aErrLane), 32'd3);
    checkField("bothErrExp", aErrExp, 32'd3);
    checkField("bothErrAct", aErrAct, 32'd7);

    // Continue to beat 20, pulse reset, then a clean re-run from the seed.
    repeat (15) applyStimulus(1'b0, 1'b0);
    checkField("midBeats1", 32'(aBeats1), 32'd20);
    checkField("midErr", 32'(aErr), 32'd1);
    c1Beat = -1; c2Beat = -1;
    applyStimulus(1'b1, 1'b0);
    checkResetA();
    runUntilDone(200, 1'b0);
    checkField("rerunErr", 32'(aErr), 32'd0);
    checkField("rerunBeats2", 32'(aBeats2), 32'(NA));
    applyStimulus(1'b0, 1'b0);
    checkField("rerunStall", 32'(aStall), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stream_checker.md
# pipe_stream_checker

Receive-side endpoint for the two-lane global-stall pipeline: consumes the `out_data_*`/`out_valid_*` streams produced by `top` and checks each lane against an expected arithmetic sequence. It drives the pipeline's global stall input with an optional pseudo-random backpressure pattern, and counts accepted beats per lane. It captures the first mismatch and signals completion after a fixed number of beats on both lanes. It sits beside `top` in the self-checking bench and gate-level sims, replacing `$display` inspection.

## Interface
- `DATA_W`, 32: lane data width.
- `SEED_1`, 32'd0: expected first value on lane 1.
- `SEED_2`, 32'd0: expected first value on lane 2.
- `STEP`, 32'd1: increment per accepted beat, both lanes.
- `NUM_BEATS`, 16'd1024: beats per lane required for done; must be ≥1.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data_1`  in  DATA_W  lane 1 data, from `out_data_1`.
- `in_valid_1`  in  1  lane 1 valid, from `out_valid_1`.
- `in_data_2`  in  DATA_W  lane 2 data.
- `in_valid_2`  in  1  lane 2 valid.
- `stall_en`  in  1  enables pseudo-random backpressure.
- `stall`  out  1  registered global stall to the pipeline.
- `beats_1`  out  16  accepted beats, lane 1.
- `beats_2`  out  16  accepted beats, lane 2.
- `err`  out  1  sticky mismatch flag.
- `err_lane`  out  2  lanes that mismatched on the capture cycle; bit0 = lane 1, bit1 = lane 2.
- `err_expected`  out  DATA_W  expected value at first mismatch.
- `err_actual`  out  DATA_W  received value at first mismatch.
- `done`  out  1  high in DONE state.

## Operation
- States: RUN (reset state) and DONE.
- RUN → DONE on the edge where `beats_1` and `beats_2` both equal NUM_BEATS after the update. DONE is left only by `reset`.
- Accept on lane x in a cycle: `in_valid_x & ~stall & state==RUN & beats_x < NUM_BEATS`. Valid beats while `stall`=1 are ignored; the pipeline holds them.
- Each lane has a DATA_W expected register, initialised to SEED_x. On accept: compare `in_data_x` to expected, then `expected += STEP` mod 2^DATA_W, then `beats_x += 1`.
- `beats_x` saturates at NUM_BEATS. Further valids on that lane are ignored, not checked.
- On mismatch with `err`=0:
  - set `err`.
  - `err_lane` gets the mismatch vector.
  - `err_expected`/`err_actual` get the lane-1 pair if lane 1 mismatched, else the lane-2 pair.
- Once `err`=1, all capture registers are frozen. Checking and counting continue.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Feedback = `l[15]^l[13]^l[12]^l[10]`, shifted into bit0. Advances only when `stall_en`=1.
- Next `stall`:
  - RUN: `stall_en & (lfsr[1:0]==2'b00)`, using the pre-advance LFSR value (≈25% duty).
  - DONE: `stall` = 1.

## Timing
- Reset values:
  - `stall`=0, `beats_1`=`beats_2`=0, `err`=0, `err_lane`=0, `err_expected`=`err_actual`=0, `done`=0.
  - LFSR = LFSR_SEED; expected registers = SEED_1/SEED_2; state = RUN.
- Reset mid-run restores all of the above on the next edge, including exiting DONE.
- `stall` is registered and sampled by the pipeline the cycle after it is computed. Acceptance uses the current registered `stall`, so sink and pipeline agree every cycle.
- `beats_x`, `err*` and `done` update on the edge ending the accept cycle (1-cycle latency).
- `done` rises on the same edge as the final `beats_x` increment. `stall`=1 from the following edge.
- Lanes are independent: simultaneous accepts on both lanes are each checked in the same cycle.
- Expected-value wrap: SEED=32'hFFFF_FFFF, STEP=1 expects 32'hFFFF_FFFF then 32'h0000_0000.

## Test plan
- Clean stream, `stall_en`=0, NUM_BEATS=8, both lanes valid every cycle with 0..7 → `beats_1`=`beats_2`=8, `err`=0, `done`=1 on the edge after the 8th beat, then `stall`=1.
- Backpressure, `stall_en`=1, LFSR_SEED=16'hACE1, 64 beats → acceptance only in cycles with `stall`=0. `stall` sequence matches a reference LFSR model bit-exact. Both lanes `done`, `err`=0.
- Lane 2 corrupted at beat 5 (sends 99, expects 5) → `err`=1, `err_lane`=2'b10, `err_expected`=5, `err_actual`=99. Later beats counted; capture unchanged after a second injected mismatch.
- Both lanes corrupted in the same cycle at beat 3 (lane 1 sends 7, lane 2 sends 9) → `err_lane`=2'b11, `err_expected`=3, `err_actual`=7.
- Wrap: SEED_1=32'hFFFF_FFFE, STEP=1, three beats FFFF_FFFE, FFFF_FFFF, 0 → no error. Extra valids after NUM_BEATS on lane 1 only → `beats_1` stays at NUM_BEATS.
- `reset` asserted for one cycle mid-run at `beats_1`=20 with `err`=1 → all outputs return to reset values on the next edge. Re-run from SEED passes.
